// File: rtl/adam_mem_pkg.sv
// adam_mem_pkg: shared FSM states and AXI response codes for the memory controller
package adam_mem_pkg;
  typedef enum logic [2:0] {PAUSED, IDLE, READ_WAIT, READ_RESP, WRITE_RESP} state_e;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
endpackage

// File: rtl/adam_mem_ctrl.sv
// adam_mem_ctrl: AXI-Lite slave to single-port SRAM bridge with pause handshake
module adam_mem_ctrl
  import adam_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE = 4096
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            pause_req,
  output logic                            pause_ack,
  input  logic [ADDR_WIDTH-1:0]           awaddr,
  input  logic                            awvalid,
  output logic                            awready,
  input  logic [DATA_WIDTH-1:0]           wdata,
  input  logic [DATA_WIDTH/8-1:0]         wstrb,
  input  logic                            wvalid,
  output logic                            wready,
  output logic [1:0]                      bresp,
  output logic                            bvalid,
  input  logic                            bready,
  input  logic [ADDR_WIDTH-1:0]           araddr,
  input  logic                            arvalid,
  output logic                            arready,
  output logic [DATA_WIDTH-1:0]           rdata,
  output logic [1:0]                      rresp,
  output logic                            rvalid,
  input  logic                            rready,
  output logic                            mem_req,
  output logic                            mem_we,
  output logic [$clog2(MEM_SIZE)-3:0]     mem_addr,
  output logic [DATA_WIDTH/8-1:0]         mem_be,
  output logic [DATA_WIDTH-1:0]           mem_wdata,
  input  logic [DATA_WIDTH-1:0]           mem_rdata
);
  localparam int MW = $clog2(MEM_SIZE);
  state_e state, state_nx;
  logic last_wr, wr_ok, rd_ok, go, sel_wr, sel_rd, done;
  assign wr_ok = awaddr < ADDR_WIDTH'(MEM_SIZE);
  assign rd_ok = araddr < ADDR_WIDTH'(MEM_SIZE);
  assign go = state == IDLE && !pause_req;
  // A pending read wins only when the last served transaction was a write
  assign sel_wr = go && awvalid && wvalid && !(arvalid && last_wr);
  assign sel_rd = go && arvalid && !sel_wr;
  assign awready = sel_wr;
  assign wready = sel_wr;
  assign arready = sel_rd;
  assign mem_req = !rst && (sel_wr ? wr_ok : sel_rd && rd_ok);
  assign mem_we = sel_wr;
  assign mem_addr = sel_wr ? awaddr[MW-1:2] : araddr[MW-1:2];
  assign mem_be = sel_wr ? wstrb : '1;
  assign mem_wdata = wdata;
  assign bvalid = state == WRITE_RESP;
  assign rvalid = state == READ_RESP;
  assign pause_ack = state == PAUSED;
  assign done = (bvalid && bready) || (rvalid && rready);
  always_comb begin
    state_nx = state;
    unique case (state)
      PAUSED:                 state_nx = pause_req ? PAUSED : IDLE;
      IDLE:                   state_nx = pause_req ? PAUSED : sel_wr ? WRITE_RESP : sel_rd ? READ_WAIT : IDLE;
      READ_WAIT:              state_nx = READ_RESP;
      READ_RESP, WRITE_RESP:  state_nx = !done ? state : pause_req ? PAUSED : IDLE;
      default:                state_nx = PAUSED;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PAUSED;
      last_wr <= 1'b0;
      bresp <= RESP_OKAY;
      rresp <= RESP_OKAY;
      rdata <= '0;
    end else begin
      state <= state_nx;
      if (sel_wr) begin
        last_wr <= 1'b1;
        bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end
      if (sel_rd) begin
        last_wr <= 1'b0;
        rresp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      end
      // SRAM data is valid only in the cycle after the read strobe
      if (state == READ_WAIT) rdata <= rresp == RESP_OKAY ? mem_rdata : '0;
    end
  end
endmodule

// File: tb/tb_adam_mem_ctrl.sv
// tb_adam_mem_ctrl: randomized scoreboard bench for adam_mem_ctrl with a byte-level memory model
module tb_adam_mem_ctrl;
  import adam_mem_pkg::*;
  localparam int MS = 4096;
  logic clk = 0, rst = 1, pause_req = 1, pause_ack;
  logic [31:0] awaddr = 0, wdata = 0, araddr = 0, rdata, mem_wdata, mem_rdata = 0;
  logic [3:0] wstrb = 0, mem_be;
  logic awvalid = 0, wvalid = 0, arvalid = 0, bready = 1, rready = 1;
  logic awready, wready, arready, bvalid, rvalid, mem_req, mem_we;
  logic [1:0] bresp, rresp;
  logic [9:0] mem_addr;

  adam_mem_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_SIZE(MS)) dut (
    .clk(clk), .rst(rst), .pause_req(pause_req), .pause_ack(pause_ack),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  always #5 clk = ~clk;
  int cyc = 0, acc_cyc = 0, tests = 0, fails = 0, rmode = 2;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] sram [MS/4];
  logic [7:0] ref_mem [MS];
  initial begin
    foreach (sram[i]) sram[i] = 0;
    foreach (ref_mem[i]) ref_mem[i] = 0;
  end
  always @(posedge clk)
    if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) if (mem_be[b]) sram[mem_addr][8*b+:8] <= mem_wdata[8*b+:8];
      end else mem_rdata <= sram[mem_addr];
    end

  always @(posedge clk) begin
    #1;
    bready = rmode == 2 || (rmode == 0 && $urandom_range(1, 0) == 1);
    rready = rmode == 2 || (rmode == 0 && $urandom_range(1, 0) == 1);
  end

  typedef struct {logic is_wr; logic [1:0] resp; logic [31:0] data;} exp_t;
  exp_t exp_q[$];
  logic last_wr_m = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(string name);
    tests++;
    fails++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // Called at the negedge where the DUT shows ready for this transaction
  task automatic accept(bit is_wr, logic [31:0] addr, logic [31:0] data, logic [3:0] strb);
    bit ok;
    int b;
    exp_t e;
    ok = addr < MS;
    b = int'(addr & 32'hFFC);
    check(is_wr ? "wr_mem_req" : "rd_mem_req", {31'd0, mem_req}, {31'd0, ok});
    if (ok) begin
      check("mem_we", {31'd0, mem_we}, {31'd0, is_wr});
      check("mem_addr", {22'd0, mem_addr}, addr[11:2]);
      check("mem_be", {28'd0, mem_be}, is_wr ? {28'd0, strb} : 32'hF);
      if (is_wr) check("mem_wdata", mem_wdata, data);
    end
    acc_cyc = cyc;
    e.is_wr = is_wr;
    e.resp = ok ? RESP_OKAY : RESP_SLVERR;
    e.data = 0;
    if (is_wr && ok)
      for (int i = 0; i < 4; i++) if (strb[i]) ref_mem[b+i] = data[8*i+:8];
    if (!is_wr && ok) e.data = {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    exp_q.push_back(e);
    last_wr_m = is_wr;
  endtask

  task automatic do_op(bit wr, bit rd, logic [31:0] aw, logic [31:0] d, logic [3:0] s, logic [31:0] ar);
    bit pw = wr, pr = rd;
    int n = 0;
    @(posedge clk); #1;
    awaddr = aw; wdata = d; wstrb = s; araddr = ar;
    awvalid = wr; wvalid = wr; arvalid = rd;
    while ((pw || pr) && n < 60) begin
      @(negedge clk);
      n++;
      if (pw && awready) begin
        if (pr) check("arb_write_first", 1, {31'd0, !last_wr_m});
        accept(1, aw, d, s);
        pw = 0;
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
      end else if (pr && arready) begin
        if (pw) check("arb_write_first", 0, {31'd0, !last_wr_m});
        accept(0, ar, 0, 0);
        pr = 0;
        @(posedge clk); #1;
        arvalid = 0;
      end
    end
    if (pw || pr) fail_now("accept_timeout");
    awvalid = 0; wvalid = 0; arvalid = 0;
  endtask

  task automatic drain();
    int n = 0;
    rmode = 2;
    while ((exp_q.size() != 0 || bvalid || rvalid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) fail_now("drain_timeout");
  endtask

  logic pbv = 0, prv = 0, pbr = 0, prr = 0;
  logic [1:0] pbresp = 0, prresp = 0;
  logic [31:0] prdata = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      pbv = 0; prv = 0;
    end else begin
      if (awready || wready) check("aw_w_together", {31'd0, awready}, {31'd0, wready});
      if (bvalid || rvalid || pause_ack || (awready && arready))
        check("ready_when_busy", {29'd0, awready, wready, arready}, 0);
      if (bvalid && pbv && !pbr) check("bresp_stable", {30'd0, bresp}, {30'd0, pbresp});
      if (rvalid && prv && !prr) begin
        check("rresp_stable", {30'd0, rresp}, {30'd0, prresp});
        check("rdata_stable", rdata, prdata);
      end
      if (bvalid && !pbv) check("b_latency", cyc - acc_cyc, 1);
      if (rvalid && !prv) check("r_latency", cyc - acc_cyc, 2);
      if ((bvalid && bready) || (rvalid && rready)) begin
        if (exp_q.size() == 0) fail_now("unexpected_response");
        else begin
          e = exp_q.pop_front();
          check("resp_kind_is_write", {31'd0, bvalid}, {31'd0, e.is_wr});
          if (bvalid) check("bresp", {30'd0, bresp}, {30'd0, e.resp});
          else begin
            check("rresp", {30'd0, rresp}, {30'd0, e.resp});
            check("rdata", rdata, e.data);
          end
        end
      end
      pbv = bvalid; prv = rvalid; pbr = bready; prr = rready;
      pbresp = bresp; prresp = rresp; prdata = rdata;
    end
  end

  initial begin
    int n;
    logic [31:0] a, a2;
    awvalid = 1; wvalid = 1; arvalid = 1; awaddr = 32'h10; araddr = 32'h10;
    repeat (3) begin
      @(negedge clk);
      check("rst_mem_req", {31'd0, mem_req}, 0);
    end
    check("rst_outputs", {25'd0, pause_ack, awready, wready, arready, bvalid, rvalid, mem_req}, 32'h40);
    check("rst_resp_data", rdata | {28'd0, bresp, rresp}, 0);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0; rst = 0;
    repeat (3) begin
      @(negedge clk);
      check("ack_while_req", {31'd0, pause_ack}, 1);
    end
    @(posedge clk); #1;
    pause_req = 0;
    @(negedge clk);
    check("ack_until_edge", {31'd0, pause_ack}, 1);
    @(negedge clk);
    check("ack_falls", {31'd0, pause_ack}, 0);
    do_op(1, 0, 32'h10, 32'hDEADBEEF, 4'b0011, 0);
    do_op(0, 1, 0, 0, 0, 32'h10);
    do_op(0, 1, 0, 0, 0, 32'h1000);
    repeat (2) do_op(1, 1, $urandom_range(255, 0), $urandom, 4'($urandom), $urandom_range(255, 0));
    drain();
    @(negedge clk);
    rmode = 1;
    do_op(0, 1, 0, 0, 0, 32'h10);
    n = 0;
    while (!rvalid && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!rvalid) fail_now("rvalid_timeout");
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    pause_req = 1;
    repeat (2) begin
      @(negedge clk);
      check("no_ack_before_rready", {30'd0, pause_ack, rvalid}, 1);
    end
    rmode = 2;
    n = 0;
    while (rvalid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("ack_after_rready", {30'd0, pause_ack, rvalid}, 2);
    @(posedge clk); #1;
    pause_req = 0;
    repeat (2) @(negedge clk);
    do_op(0, 1, 0, 0, 0, 32'h20);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    exp_q.delete();
    last_wr_m = 0;
    @(negedge clk);
    check("rst_in_wait", {30'd0, rvalid, pause_ack}, 1);
    repeat (6) @(negedge clk);
    repeat (80) begin
      rmode = $urandom_range(1, 0) * 2;
      a = $urandom_range(9, 0) == 0 ? 32'h1000 | $urandom : $urandom_range(255, 0);
      a2 = $urandom_range(9, 0) == 0 ? MS + $urandom_range(1023, 0) : $urandom_range(255, 0);
      case ($urandom_range(2, 0))
        0: do_op(1, 0, a, $urandom, 4'($urandom), 0);
        1: do_op(0, 1, 0, 0, 0, a2);
        default: do_op(1, 1, a, $urandom, 4'($urandom), a2);
      endcase
      if ($urandom_range(7, 0) == 0) begin
        @(posedge clk); #1;
        pause_req = 1;
        repeat (3) @(posedge clk);
        #1 pause_req = 0;
      end
    end
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
